// File: rtl/axis_to_axil_pkg.sv
// Shared constants for the AXI-Stream to AXI-Lite block loader.
package axis_to_axil_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axis_to_axil_writer.sv
// Streams a block of words into an AXI-Lite slave, one outstanding write at a time.
// Optional AXIS_TO_AXIL_ERRCNT_EN adds a saturating count of non-OKAY write responses.
module axis_to_axil_writer
    import axis_to_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef AXIS_TO_AXIL_ERRCNT_EN
    output logic [7:0]            err_count,
`endif
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    localparam int OFF_WIDTH = LEN_WIDTH + $clog2(STRB_WIDTH + 1);

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
    logic [7:0]            err_cnt_q, err_cnt_d;
`endif

    logic [OFF_WIDTH-1:0]  byte_off;
    logic                  idx_is_last;
    logic                  aw_clear;
    logic                  w_clear;

    assign byte_off    = OFF_WIDTH'(idx_q) * OFF_WIDTH'(STRB_WIDTH);
    assign idx_is_last = (idx_q == len_q - LEN_WIDTH'(1));
    assign aw_clear    = !awvalid_q || m_axil_awready;
    assign w_clear     = !wvalid_q || m_axil_wready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        base_d    = base_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        last_d    = last_q;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
                    err_cnt_d = 8'd0;
`endif
                    if (len != '0) begin
                        base_d  = base_addr;
                        len_d   = len;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (s_axis_tvalid) begin
                    wdata_d   = s_axis_tdata;
                    awaddr_d  = base_q + ADDR_WIDTH'(byte_off);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    last_d    = idx_is_last || s_axis_tlast;
                    // tlast and the word count disagreeing either way is a framing error
                    if (idx_is_last != s_axis_tlast) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (m_axil_awready) begin
                    awvalid_d = 1'b0;
                end
                if (m_axil_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_clear && w_clear) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
`endif
                    end
                    if (last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + LEN_WIDTH'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            base_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= 1'b0;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
            err_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            base_q    <= base_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            last_q    <= last_d;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
    assign err_count      = err_cnt_q;
`endif
    assign s_axis_tready  = (state_q == ST_FETCH);
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state_q == ST_RESP);

endmodule

// File: tb/tb_axis_to_axil_writer.sv
// Scoreboard bench for axis_to_axil_writer: expected writes are queued at stimulus time
// and popped by an independent monitor as the AXI-Lite handshakes complete.
module tb_axis_to_axil_writer;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int LW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
`ifdef AXIS_TO_AXIL_ERRCNT_EN
    logic [7:0]    err_count;
`endif
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_awvalid;
    logic          m_axil_awready;
    logic [DW-1:0] m_axil_wdata;
    logic [SW-1:0] m_axil_wstrb;
    logic          m_axil_wvalid;
    logic          m_axil_wready;
    logic [1:0]    m_axil_bresp;
    logic          m_axil_bvalid;
    logic          m_axil_bready;

    axis_to_axil_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .err            (err),
`ifdef AXIS_TO_AXIL_ERRCNT_EN
        .err_count      (err_count),
`endif
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int aw_delay = 0;
    int w_delay  = 0;
    int err_word = -1;
    int b_count  = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    bit aw_pend  = 0;
    bit w_pend   = 0;
    bit b_pend   = 0;
    bit aw_done  = 0;
    bit w_done   = 0;

    int done_count  = 0;
    int split_count = 0;

    int done_base;
    int b_base;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // AXI-Lite slave: readies after a programmable wait, B follows once both AW and W are taken
    initial begin
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b0;
        m_axil_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                m_axil_awready = 1'b0;
                m_axil_wready  = 1'b0;
                m_axil_bvalid  = 1'b0;
                aw_pend = 0; w_pend = 0; b_pend = 0;
                aw_done = 0; w_done = 0;
                aw_cnt  = 0; w_cnt  = 0;
            end else begin
                if (aw_pend) aw_done = 1;
                if (w_pend) w_done = 1;
                if (b_pend) begin
                    m_axil_bvalid = 1'b0;
                    aw_done = 0;
                    w_done  = 0;
                    b_count++;
                end else if (aw_done && w_done && !m_axil_bvalid) begin
                    m_axil_bvalid = 1'b1;
                    m_axil_bresp  = (b_count == err_word) ? 2'b10 : 2'b00;
                end
                if (m_axil_awvalid) begin
                    m_axil_awready = (aw_cnt >= aw_delay);
                    aw_cnt++;
                end else begin
                    m_axil_awready = 1'b0;
                    aw_cnt = 0;
                end
                if (m_axil_wvalid) begin
                    m_axil_wready = (w_cnt >= w_delay);
                    w_cnt++;
                end else begin
                    m_axil_wready = 1'b0;
                    w_cnt = 0;
                end
                aw_pend = m_axil_awvalid && m_axil_awready;
                w_pend  = m_axil_wvalid && m_axil_wready;
                b_pend  = m_axil_bvalid && m_axil_bready;
            end
        end
    end

    // Monitor: pairs AW and W beats and checks them against the expected-write queue
    initial begin
        logic [AW-1:0] got_addr;
        logic [DW-1:0] got_data;
        bit have_a;
        bit have_w;
        wr_t e;
        have_a = 0;
        have_w = 0;
        got_addr = '0;
        got_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                have_a = 0;
                have_w = 0;
            end else begin
                if (done) done_count++;
                if (m_axil_awvalid && !m_axil_wvalid) split_count++;
                if (aw_pend) begin
                    got_addr = m_axil_awaddr;
                    have_a = 1;
                end
                if (w_pend) begin
                    got_data = m_axil_wdata;
                    have_w = 1;
                end
                if (have_a && have_w) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                                 got_addr, got_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("awaddr", 64'(got_addr), 64'(e.addr));
                        checkOutput("wdata", 64'(got_data), 64'(e.data));
                    end
                    have_a = 0;
                    have_w = 0;
                end
            end
        end
    end

    // Start a transfer, queue the writes it should produce, and feed n_beats stream words
    task automatic applyStimulus(input logic [AW-1:0] base, input int n_len, input int n_beats,
                                 input int tlast_beat, input logic [DW-1:0] data_base);
        wr_t w;
        int guard;
        done_base = done_count;
        b_base    = b_count;
        for (int i = 0; i < n_beats; i++) begin
            w.addr = base + AW'(i * SW);
            w.data = data_base + DW'(i);
            exp_q.push_back(w);
        end
        @(negedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        len       = LW'(n_len);
        @(negedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < n_beats; i++) begin
            s_axis_tdata  = data_base + DW'(i);
            s_axis_tlast  = (i == tlast_beat);
            s_axis_tvalid = 1'b1;
            guard = 0;
            while (!s_axis_tready && guard < 200) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL tready_timeout: got no tready on beat %0d, expected tready", i);
                break;
            end
            @(negedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic finishTransfer(input string name, input int exp_writes, input logic exp_err);
        int guard;
        guard = 0;
        while (done_count == done_base && guard < 300) begin
            @(negedge clk);
            #3;
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_done_timeout: got no done pulse, expected one", name);
        end
        repeat (4) @(negedge clk);
        #3;
        checkOutput({name, "_done_pulses"}, 64'(done_count - done_base), 64'd1);
        checkOutput({name, "_err"}, 64'(err), 64'(exp_err));
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_b_handshakes"}, 64'(b_count - b_base), 64'(exp_writes));
        checkOutput({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int split_base;
        int guard;
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        len           = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_tready", 64'(s_axis_tready), 64'd0);
        checkOutput("rst_awvalid", 64'(m_axil_awvalid), 64'd0);
        checkOutput("rst_wvalid", 64'(m_axil_wvalid), 64'd0);
        checkOutput("rst_bready", 64'(m_axil_bready), 64'd0);
        checkOutput("rst_awaddr", 64'(m_axil_awaddr), 64'd0);
        checkOutput("rst_wdata", 64'(m_axil_wdata), 64'd0);
        rst = 1'b0;

        // Basic 4-word block: 0x040..0x04C
        applyStimulus(9'h040, 4, 4, 3, 32'h0000_00A0);
        finishTransfer("basic", 4, 1'b0);
        checkOutput("basic_awprot", 64'(m_axil_awprot), 64'd0);
        checkOutput("basic_wstrb", 64'(m_axil_wstrb), 64'hF);

        // Slow AW channel: W completes first and AW is held 3 extra cycles per word
        aw_delay   = 3;
        split_base = split_count;
        applyStimulus(9'h080, 2, 2, 1, 32'h0000_00B0);
        finishTransfer("slow_aw", 2, 1'b0);
        checkOutput("slow_aw_split_cycles", 64'(split_count - split_base), 64'd6);
        aw_delay = 0;

        // Early tlast on the 2nd of 4 words
        applyStimulus(9'h020, 4, 2, 1, 32'h0000_1100);
        finishTransfer("early_tlast", 2, 1'b1);

        // Zero-length start clears err and pulses done with no bus traffic
        applyStimulus(9'h000, 0, 0, -1, 32'h0);
        finishTransfer("zero_len", 0, 1'b0);

        // Count reached without tlast
        applyStimulus(9'h100, 2, 2, -1, 32'h0000_2200);
        finishTransfer("missing_tlast", 2, 1'b1);

        // SLVERR on word 1 of 3
        err_word = b_count + 1;
        applyStimulus(9'h010, 3, 3, 2, 32'h0000_00C0);
        finishTransfer("slverr", 3, 1'b1);
`ifdef AXIS_TO_AXIL_ERRCNT_EN
        checkOutput("slverr_err_count", 64'(err_count), 64'd1);
`endif
        err_word = -1;

        // Address wrap: 0x1F8, 0x1FC, 0x000, 0x004
        applyStimulus(9'h1F8, 4, 4, 3, 32'h0000_00D0);
        finishTransfer("wrap", 4, 1'b0);

        // Reset in WRITE aborts without a done pulse
        aw_delay = 100;
        w_delay  = 100;
        applyStimulus(9'h100, 2, 1, -1, 32'h0000_0055);
        guard = 0;
        while (!m_axil_awvalid && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput("abort_in_write", 64'(m_axil_awvalid), 64'd1);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_awvalid", 64'(m_axil_awvalid), 64'd0);
        checkOutput("abort_wvalid", 64'(m_axil_wvalid), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst      = 1'b0;
        aw_delay = 0;
        w_delay  = 0;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("abort_no_done", 64'(done_count - done_base), 64'd0);

        // Clean transfer after the aborted one
        applyStimulus(9'h010, 2, 2, 1, 32'h0000_0060);
        finishTransfer("after_reset", 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
